// File: rtl/bus_share_pkg.sv
// Shared constants and types for the two-source bus share arbiter.
package bus_share_pkg;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W_DEF     = 4;
   localparam int unsigned DATA_W        = 4;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_GRANT0 = 2'b01;
   localparam logic [1:0] ST_GRANT1 = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_GRANT0 = ST_GRANT0,
      S_GRANT1 = ST_GRANT1
   } state_t;

   // Grant state that owns source k.
   function automatic state_t grant_of(input logic k);
      return k ? S_GRANT1 : S_GRANT0;
   endfunction

endpackage

// File: rtl/four_bit_2x1_mux.sv
// Four-bit two-to-one multiplexer: Out follows In_1 when Select is high.
module four_bit_2x1_mux
   import bus_share_pkg::*;
(
   input  logic [DATA_W-1:0] In_1,
   input  logic [DATA_W-1:0] In_0,
   input  logic              Select,
   output logic [DATA_W-1:0] Out
);

   assign Out = Select ? In_1 : In_0;

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin burst arbiter sharing one 4-bit channel between two sources
// by steering the select line of a 2:1 mux; valid/ready toward the consumer.
module bus_share_arbiter
   import bus_share_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_0,
   input  logic              Req_1,
   input  logic [DATA_W-1:0] In_0,
   input  logic [DATA_W-1:0] In_1,
   output logic              Ack_0,
   output logic              Ack_1,
   output logic [DATA_W-1:0] Out,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic              Select,
   output logic              Busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   state_t           state, state_nx;
   logic             last_grant, last_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             k, cur_req, other_req, xfer, done;

   // Next-state, burst counter and handshake decode.
   always_comb begin
      state_nx  = state;
      last_nx   = last_grant;
      cnt_nx    = cnt;
      Out_Valid = 1'b0;
      Ack_0     = 1'b0;
      Ack_1     = 1'b0;
      k         = 1'b0;
      cur_req   = 1'b0;
      other_req = 1'b0;
      xfer      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            if (Req_0 && Req_1) state_nx = grant_of(!last_grant);
            else if (Req_0)     state_nx = S_GRANT0;
            else if (Req_1)     state_nx = S_GRANT1;
         end
         S_GRANT0, S_GRANT1: begin
            k         = (state == S_GRANT1);
            cur_req   = k ? Req_1 : Req_0;
            other_req = k ? Req_0 : Req_1;
            Out_Valid = cur_req;
            xfer      = cur_req & Out_Ready;
            Ack_0     = xfer & ~k;
            Ack_1     = xfer & k;
            done      = xfer && (cnt == CNT_LAST);
            // Release on burst completion or source withdrawal.
            if (done || !cur_req) begin
               last_nx = k;
               cnt_nx  = '0;
               if (other_req)           state_nx = grant_of(!k);
               else if (done && cur_req) state_nx = grant_of(k);
               else                      state_nx = S_IDLE;
            end else if (xfer) begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // State register; Select and Busy are registered from the next state.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         Select     <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         last_grant <= last_nx;
         cnt        <= cnt_nx;
         Busy       <= (state_nx != S_IDLE);
         if (state_nx != S_IDLE) Select <= (state_nx == S_GRANT1);
      end
   end

   four_bit_2x1_mux u_mux (
      .In_1   (In_1),
      .In_0   (In_0),
      .Select (Select),
      .Out    (Out)
   );

endmodule

// File: doc/bus_share_arbiter.md
# bus_share_arbiter

Round-robin arbiter that shares one 4-bit output channel between two requesters by sequencing the `Select` line of the team's `four_bit_2x1_mux`. It grants the channel for bursts of up to `MAX_BURST` words and moves words to a downstream consumer with a valid/ready handshake. It acknowledges each word back to its source. It sits between two 4-bit producers and a single 4-bit consumer port.

## Interface
- `MAX_BURST`, default 4: maximum words per grant; legal range 1..15.
- `CNT_W`, default 4: width of the burst counter; must satisfy 2^CNT_W > MAX_BURST.

- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: reset, asynchronous and active-low.
- `Req_0`, `Req_1` in 1: source requests; each is held high while that source has a word on its data input.
- `In_0`, `In_1` in 4: source data; must stay stable while `Req_k`=1 and `Ack_k`=0.
- `Ack_0`, `Ack_1` out 1: combinational; high in the cycle source k's word is accepted.
- `Out` out 4: mux output, `In_Select`.
- `Out_Valid` out 1: combinational; channel holds a valid word.
- `Out_Ready` in 1: consumer accepts the word when `Out_Valid`=1 at the edge.
- `Select` out 1: current mux select, registered.
- `Busy` out 1: high in any grant state.

## Operation
- States:
  - IDLE
  - GRANT0 (`Select`=0)
  - GRANT1 (`Select`=1)
- Registers:
  - state
  - `Last_Grant` (1 bit)
  - burst counter `Cnt` (`CNT_W` bits)
- In GRANTk:
  - `Out_Valid` = `Req_k`.
  - A transfer happens when `Out_Valid` & `Out_Ready`.
  - `Ack_k` = transfer; `Ack` of the other source = 0.
- IDLE:
  - No requests: stay in IDLE.
  - One request: go to that source's GRANT.
  - Both requesting: go to GRANT(!`Last_Grant`).
  - `Cnt` is cleared on every grant entry.
- Release from GRANTk happens at the edge when either condition holds:
  - (a) transfer with `Cnt`=`MAX_BURST`-1 (burst complete);
  - (b) `Req_k`=0 (source withdrew).
- On release:
  - `Last_Grant` ← k.
  - Next state is GRANT(1-k) if `Req_(1-k)`=1.
  - Otherwise, if (a) and `Req_k`=1: re-enter GRANTk with `Cnt`=0.
  - Otherwise IDLE.
- No release: `Cnt` increments on each transfer; it holds when there is no transfer.
- `Cnt` never exceeds `MAX_BURST`-1 and never wraps.
- `Req_k` dropping mid-burst is legal: no `Ack` that cycle, and the channel is released.
- `Out_Ready` low stalls indefinitely: state, `Cnt` and `Select` hold, and `Out`/`Out_Valid` stay stable.
- `MAX_BURST`=1: every transfer releases, giving strict word-by-word alternation when both sources request.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, `Last_Grant`=1 (source 0 wins the first tie), `Cnt`=0, `Select`=0.
  - Hence `Out`=`In_0`, `Out_Valid`=0, `Ack_0`=`Ack_1`=0, `Busy`=0.
- Reset mid-burst aborts immediately with no `Ack`. The partially sent burst is not resumed.

## Timing
- Grant latency: `Req_k` rising before edge n gives the grant at edge n. `Out_Valid` and `Select` are valid in cycle n+1.
- Throughput: one word per cycle while `Out_Ready`=1.
- Handover between sources takes no idle cycle: the last word of source k is at edge m, and source 1-k's first word is available in cycle m+1.
- `Ack`, `Out_Valid` and `Out` are combinational from registered state and the inputs. There is no combinational path from `Out_Ready` to `Select`.
- Simultaneous `Req_k` fall and transfer cannot occur: a transfer requires `Req_k`=1.

## Structure
- Shared package `bus_share_pkg`:
  - state encoding constants `ST_IDLE`=2'b00, `ST_GRANT0`=2'b01, `ST_GRANT1`=2'b10;
  - default `MAX_BURST`.
- One sub-module: `four_bit_2x1_mux` instance, wired (`In_1`, `In_0`, `Select`, `Out`). The arbiter adds no logic on the data path.
- Next-state logic, `Cnt` and `Last_Grant` are in the top module.

## Test plan
- Reset, then `Req_0`=1 with `In_0`=4'hA and `Out_Ready`=1:
  - cycle 1: `Select`=0, `Out`=4'hA, `Out_Valid`=1, `Ack_0`=1;
  - after 4 transfers with only `Req_0` high, re-grant to 0 with `Cnt`=0.
- Both requesting from reset, `In_0`=4'h3, `In_1`=4'hC, `Out_Ready`=1, `MAX_BURST`=4:
  - output sequence 3,3,3,3,C,C,C,C,3…;
  - no idle cycle at handovers.
- `Out_Ready`=0 for 5 cycles mid-burst (`Cnt`=2): `Out`, `Select` and `Cnt` frozen; no `Ack`; 2 more words complete the burst after release.
- `Req_1` dropped after 2 words while `Req_0`=1: next edge grants 0 and `Last_Grant`=1.
- `Rst_n` pulsed low mid-burst in GRANT1 (async, between edges): outputs go to reset values immediately; the next tie goes to source 0.
- `MAX_BURST`=1 with both requesting: `Select` toggles every accepted word, pattern 0,1,0,1.
